bcedn_pool_index_writer: RTL
============================

// Module: bcedn_pool_index_writer
// PURPOSE
// Encoder-side max-unpool companion: takes POOL_H*POOL_W pre-threshold popcount scores per PE lane,
// selects the max, binarises it against norm_ref, and writes the argmax pooling index to the index SRAM.
// Produces the index stream the decoder reads back for unpooling.
// Packs pooled bits into FD-wide output words for the next encoder stage.
// PARAMETERS
// H 32; input map height (pre-pool)
// W 128; input map width (pre-pool)
// D 512; input depth; sets SCORE_W
// FH 3; filter height; sets SCORE_W
// FW 3; filter width; sets SCORE_W
// FD 512; output channels
// N_PE 1; parallel lanes; FD % N_PE == 0
// POOL_H 2; pool window height; POOL_H*POOL_W is 1 or 4
// POOL_W 2; pool window width; POOL_H*POOL_W is 1 or 4
// NORMREF_WIDTH 15; per-lane threshold width
// localparams:
//   SCORE_W = $clog2(FH*FW*D+1)
//   NPOS = POOL_H*POOL_W
//   PINDEX_WIDTH = max($clog2(NPOS),1)
//   GROUPS = FD/N_PE
//   INDEX_SRAM_DEPTH = (H/POOL_H)*(W/POOL_W)*GROUPS
//   INDEX_ADDR_WIDTH = $clog2(INDEX_SRAM_DEPTH)
// PORTS
// clk             in   1                        clock
// rst             in   1                        sync active-high reset
// start           in   1                        arm/restart frame
// in_en           in   1                        score_in/norm_ref valid for one group
// score_in        in   N_PE*NPOS*SCORE_W        lane0 MSBs; inside a lane pos0 (top-left) MSBs, then TR, BL, BR
// norm_ref        in   N_PE*NORMREF_WIDTH       per-lane threshold; lane0 MSBs
// pindex_wr       out  1                        index SRAM write strobe
// pindex_wr_addr  out  INDEX_ADDR_WIDTH         index SRAM write address
// pindex_wr_data  out  PINDEX_WIDTH*N_PE        argmax per lane; lane0 MSBs
// data_out        out  FD                       packed pooled bits; group0 in the MSBs
// out_en          out  1                        data_out valid, 1-cycle pulse
// frame_done      out  1                        last index written, 1-cycle pulse
// busy            out  1                        high in RUN
// BEHAVIOUR
// - Reset (rst=1 at posedge): state IDLE; all outputs 0, including data_out, pindex_wr_addr and all counters.
// - FSM IDLE->RUN on start. RUN->IDLE on the in_en that writes addr INDEX_SRAM_DEPTH-1.
//   In RUN, start clears addr/group counters and drops the in_en of that same cycle.
//   start takes priority.
// - in_en is ignored in IDLE; no write and no out_en.
// - Per lane (comb):
//   - max over NPOS unsigned scores.
//   - Ties: lowest position wins (TL=0, TR=1, BL=2, BR=3).
//   - bit = (max >= zero-extended norm_ref).
//   - For NPOS=1, index is always 0.
// - Latency 1: an in_en accepted at cycle t gives, at t+1:
//   - pindex_wr=1;
//   - pindex_wr_addr = addr counter value at t;
//   - pindex_wr_data = the registered argmax.
// - Address order: addr = (row*W_OUT + col)*GROUPS + group. Increments by 1 per accepted in_en.
// - Group counter 0..GROUPS-1:
//   - Lane bits shift into a packing register; group g occupies data_out[FD-1-g*N_PE -: N_PE].
//   - On group GROUPS-1: data_out loads the full word and out_en=1 at t+1. data_out holds until the next full word.
// - Final write (addr INDEX_SRAM_DEPTH-1): frame_done=1 at t+1, together with pindex_wr and out_en.
//   The address wraps to 0 and busy drops at t+1.
// - rst mid-frame: the pending write is discarded and nothing is issued at t+1.
// - Back-to-back in_en at full rate is supported; no stall path. Gaps in in_en are allowed.
// STRUCTURE
// - Shared package bcedn_pkg:
//   - pindex_width(npos) function;
//   - pool position encoding TL=0 / TR=1 / BL=2 / BR=3 (same encoding the decoder unpool mux uses);
//   - FSM enum {IDLE, RUN}.
// - Sub-module pool_argmax_lane: combinational max, argmax and threshold for one lane. Generated N_PE times.
// - Top level: FSM, addr/group counters, output registers, packing register.
// TESTING
// Default config: H=4, W=4, FD=4, N_PE=2, 2x2 pool, D=1, FH=FW=3 -> SCORE_W=4, GROUPS=2, DEPTH=8.
// 1. Lane0 scores {3,7,7,1}, ref 5 -> next cycle pindex_wr=1, addr 0, lane0 data=2'b01, lane0 bit=1.
// 2. All scores 0, ref 0 -> index 00, bit 1 (>= is inclusive).
// 3. Eight consecutive in_en ->
//    - addrs 0..7;
//    - out_en on the 2nd, 4th, 6th and 8th writes;
//    - frame_done with addr 7;
//    - busy=0 afterwards; a 9th in_en produces no write.
// 4. in_en before start -> no pindex_wr. Then start, then in_en -> write at addr 0.
// 5. After 3 writes, start+in_en in the same cycle -> no write that cycle. The next in_en writes addr 0.
// 6. rst asserted the cycle after an in_en -> pindex_wr stays 0. All outputs 0. State IDLE.

Source files
------------

// File: rtl/bcedn_pkg.sv
// Shared definitions for the encoder pooling index path and the decoder unpool mux.
package bcedn_pkg;

   // Pool window position encoding, shared with the decoder unpool mux.
   typedef enum logic [1:0] {
      POS_TL = 2'd0,
      POS_TR = 2'd1,
      POS_BL = 2'd2,
      POS_BR = 2'd3
   } pool_pos_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Width of one pooling index; a 1x1 window still carries one (always zero) bit.
   function automatic int unsigned pindex_width(input int unsigned npos);
      return (npos > 1) ? $clog2(npos) : 1;
   endfunction

endpackage

// File: rtl/bcedn_pool_index_writer_if.sv
// Score/threshold input bus and index-SRAM / packed-word output bus of the index writer.
interface bcedn_pool_index_writer_if
   import bcedn_pkg::*;
#(
   parameter int unsigned H             = 32,
   parameter int unsigned W             = 128,
   parameter int unsigned D             = 512,
   parameter int unsigned FH            = 3,
   parameter int unsigned FW            = 3,
   parameter int unsigned FD            = 512,
   parameter int unsigned N_PE          = 1,
   parameter int unsigned POOL_H        = 2,
   parameter int unsigned POOL_W        = 2,
   parameter int unsigned NORMREF_WIDTH = 15
);
   localparam int unsigned SCORE_W          = $clog2(FH*FW*D+1);
   localparam int unsigned NPOS             = POOL_H*POOL_W;
   localparam int unsigned PINDEX_WIDTH     = pindex_width(NPOS);
   localparam int unsigned GROUPS           = FD/N_PE;
   localparam int unsigned INDEX_SRAM_DEPTH = (H/POOL_H)*(W/POOL_W)*GROUPS;
   localparam int unsigned INDEX_ADDR_WIDTH = (INDEX_SRAM_DEPTH > 1) ? $clog2(INDEX_SRAM_DEPTH) : 1;

   logic                               start;
   logic                               in_en;
   logic [N_PE*NPOS*SCORE_W-1:0]       score_in;
   logic [N_PE*NORMREF_WIDTH-1:0]      norm_ref;
   logic                               pindex_wr;
   logic [INDEX_ADDR_WIDTH-1:0]        pindex_wr_addr;
   logic [PINDEX_WIDTH*N_PE-1:0]       pindex_wr_data;
   logic [FD-1:0]                      data_out;
   logic                               out_en;
   logic                               frame_done;
   logic                               busy;

   modport master (
      output start, in_en, score_in, norm_ref,
      input  pindex_wr, pindex_wr_addr, pindex_wr_data, data_out, out_en, frame_done, busy
   );

   modport slave (
      input  start, in_en, score_in, norm_ref,
      output pindex_wr, pindex_wr_addr, pindex_wr_data, data_out, out_en, frame_done, busy
   );

endinterface

// File: rtl/pool_argmax_lane.sv
// One PE lane: max and argmax over the pool window, and binarisation against the lane threshold.
module pool_argmax_lane
   import bcedn_pkg::*;
#(
   parameter int unsigned NPOS          = 4,
   parameter int unsigned SCORE_W       = 4,
   parameter int unsigned NORMREF_WIDTH = 15,
   parameter int unsigned PINDEX_WIDTH  = 2
) (
   input  logic [NPOS*SCORE_W-1:0]  scores_i,
   input  logic [NORMREF_WIDTH-1:0] norm_ref_i,
   output logic [PINDEX_WIDTH-1:0]  argmax_c_o,
   output logic                     pool_bit_c_o
);
   localparam int unsigned CMP_W = (SCORE_W > NORMREF_WIDTH) ? SCORE_W : NORMREF_WIDTH;

   logic [SCORE_W-1:0] max_c;
   logic [SCORE_W-1:0] cand_c;

   // Strict compare keeps the lowest position on ties; position 0 (TL) sits in the MSBs.
   always_comb begin
      max_c      = scores_i[(NPOS-1)*SCORE_W +: SCORE_W];
      argmax_c_o = PINDEX_WIDTH'(POS_TL);
      cand_c     = '0;
      for (int p = 1; p < NPOS; p++) begin
         cand_c = scores_i[(NPOS-1-p)*SCORE_W +: SCORE_W];
         if (cand_c > max_c) begin
            max_c      = cand_c;
            argmax_c_o = PINDEX_WIDTH'(p);
         end
      end
      pool_bit_c_o = (CMP_W'(max_c) >= CMP_W'(norm_ref_i));
   end

endmodule

// File: rtl/bcedn_pool_index_writer.sv
// Encoder max-pool index writer: argmax indices to the index SRAM, pooled bits packed into FD-wide words.
module bcedn_pool_index_writer
   import bcedn_pkg::*;
#(
   parameter int unsigned H             = 32,
   parameter int unsigned W             = 128,
   parameter int unsigned D             = 512,
   parameter int unsigned FH            = 3,
   parameter int unsigned FW            = 3,
   parameter int unsigned FD            = 512,
   parameter int unsigned N_PE          = 1,
   parameter int unsigned POOL_H        = 2,
   parameter int unsigned POOL_W        = 2,
   parameter int unsigned NORMREF_WIDTH = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   bcedn_pool_index_writer_if.slave   bus_if
);
   localparam int unsigned SCORE_W          = $clog2(FH*FW*D+1);
   localparam int unsigned NPOS             = POOL_H*POOL_W;
   localparam int unsigned PINDEX_WIDTH     = pindex_width(NPOS);
   localparam int unsigned GROUPS           = FD/N_PE;
   localparam int unsigned INDEX_SRAM_DEPTH = (H/POOL_H)*(W/POOL_W)*GROUPS;
   localparam int unsigned INDEX_ADDR_WIDTH = (INDEX_SRAM_DEPTH > 1) ? $clog2(INDEX_SRAM_DEPTH) : 1;
   localparam int unsigned GROUP_W          = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int unsigned LANE_W           = NPOS*SCORE_W;

   localparam logic [INDEX_ADDR_WIDTH-1:0] LAST_ADDR  = INDEX_ADDR_WIDTH'(INDEX_SRAM_DEPTH-1);
   localparam logic [GROUP_W-1:0]          LAST_GROUP = GROUP_W'(GROUPS-1);

   state_e                          state_q, state_d;
   logic [INDEX_ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [GROUP_W-1:0]              group_q, group_d;
   logic [FD-1:0]                   pack_q, pack_d;
   logic [FD-1:0]                   data_out_q, data_out_d;
   logic                            wr_q, wr_d;
   logic [INDEX_ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
   logic [PINDEX_WIDTH*N_PE-1:0]    wr_data_q, wr_data_d;
   logic                            out_en_q, out_en_d;
   logic                            done_q, done_d;
   logic                            busy_q, busy_d;

   logic [PINDEX_WIDTH*N_PE-1:0]    lane_idx_c;
   logic [N_PE-1:0]                 lane_bits_c;
   logic [FD-1:0]                   full_word_c;

   // Per-lane argmax/threshold; lane 0 occupies the MSBs of every lane-packed vector.
   for (genvar l = 0; l < N_PE; l++) begin : g_lane
      pool_argmax_lane #(
         .NPOS          (NPOS),
         .SCORE_W       (SCORE_W),
         .NORMREF_WIDTH (NORMREF_WIDTH),
         .PINDEX_WIDTH  (PINDEX_WIDTH)
      ) u_lane (
         .scores_i     (bus_if.score_in[(N_PE-1-l)*LANE_W +: LANE_W]),
         .norm_ref_i   (bus_if.norm_ref[(N_PE-1-l)*NORMREF_WIDTH +: NORMREF_WIDTH]),
         .argmax_c_o   (lane_idx_c[(N_PE-1-l)*PINDEX_WIDTH +: PINDEX_WIDTH]),
         .pool_bit_c_o (lane_bits_c[N_PE-1-l])
      );
   end

   // Shifting the newest group into the LSBs leaves group 0 in the MSBs after GROUPS shifts.
   assign full_word_c = FD'({pack_q, lane_bits_c});

   // Next-state and output decode; start always wins over in_en.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      group_d    = group_q;
      pack_d     = pack_q;
      data_out_d = data_out_q;
      wr_d       = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      out_en_d   = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus_if.start) begin
               state_d = RUN;
               addr_d  = '0;
               group_d = '0;
            end
         end
         RUN: begin
            if (bus_if.start) begin
               addr_d  = '0;
               group_d = '0;
            end else if (bus_if.in_en) begin
               wr_d      = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = lane_idx_c;
               pack_d    = full_word_c;
               if (group_q == LAST_GROUP) begin
                  group_d    = '0;
                  data_out_d = full_word_c;
                  out_en_d   = 1'b1;
               end else begin
                  group_d = group_q + GROUP_W'(1);
               end
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  addr_d = addr_q + INDEX_ADDR_WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   // State, counters and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         group_q    <= '0;
         pack_q     <= '0;
         data_out_q <= '0;
         wr_q       <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         out_en_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         group_q    <= group_d;
         pack_q     <= pack_d;
         data_out_q <= data_out_d;
         wr_q       <= wr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         out_en_q   <= out_en_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus_if.pindex_wr      = wr_q;
   assign bus_if.pindex_wr_addr = wr_addr_q;
   assign bus_if.pindex_wr_data = wr_data_q;
   assign bus_if.data_out       = data_out_q;
   assign bus_if.out_en         = out_en_q;
   assign bus_if.frame_done     = done_q;
   assign bus_if.busy           = busy_q;

endmodule
